// File: rtl/audio_sched_pkg.sv
// Shared types and constants for the frame-synchronous audio capture scheduler.
package audio_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_FFT    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_COMMIT = 3'd4
    } sched_state_t;

    localparam int DEFAULT_TIMEOUT_CYC = 2000000;
    localparam int DROP_CNT_W          = 8;

    function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sched_timeout_ctr.sv
// Stage watchdog: counts cycles since the last clear and flags the final allowed cycle.
module sched_timeout_ctr
    import audio_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk_25,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk_25) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign expired = (cnt == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/capture_scheduler.sv
// Frame-synchronous sequencer: sample -> FFT -> hold until vblank -> commit.
// Define SCHED_FFT_BYPASS_EN to skip the FFT stage (raw-sample bring-up).
module capture_scheduler
    import audio_sched_pkg::*;
#(
    parameter int FRAME_DIV   = 1,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                  clk_25,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  vsync,
    input  logic                  in_vblank,
    output logic                  samp_start,
    input  logic                  samp_done,
    output logic                  fft_start,
    input  logic                  fft_done,
    output logic                  commit,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [DROP_CNT_W-1:0] frames_dropped,
    input  logic                  err_clr,
    output logic [2:0]            state_o
);

    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FRAME_DIV - 1);

    sched_state_t     state, state_next;
    logic             vsync_q, frame_tick, trigger, first_q;
    logic [DIV_W-1:0] div_cnt;
    logic             samp_ok, fft_ok, to_expired, to_clear, to_en;
    logic             timeout_evt, drop_evt;
    logic             samp_start_d, fft_start_d, commit_d;

    assign frame_tick = vsync_q & ~vsync;
    assign trigger    = frame_tick & (div_cnt == DIV_MAX) & enable;
    // A done seen on the entry cycle may be a stale level from the previous run.
    assign samp_ok    = samp_done & ~first_q;
`ifdef SCHED_FFT_BYPASS_EN
    logic unused_fft_done;
    assign unused_fft_done = fft_done;
    assign fft_ok          = 1'b0;
`else
    assign fft_ok          = fft_done & ~first_q;
`endif
    assign to_clear = (state_next != state);
    assign to_en    = (state == ST_SAMPLE) || (state == ST_FFT);
    assign drop_evt = trigger & (state != ST_IDLE);

    sched_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) u_timeout (
        .clk_25 (clk_25),
        .rst    (rst),
        .clear  (to_clear),
        .en     (to_en),
        .expired(to_expired)
    );

    always_ff @(posedge clk_25) begin
        if (rst) begin
            state   <= ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state   <= state_next;
            first_q <= (state_next != state);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (trigger) state_next = ST_SAMPLE;
            ST_SAMPLE: begin
                if (samp_ok) begin
`ifdef SCHED_FFT_BYPASS_EN
                    state_next = ST_HOLD;
`else
                    state_next = ST_FFT;
`endif
                end else if (to_expired) begin
                    state_next = ST_IDLE;
                end
            end
`ifndef SCHED_FFT_BYPASS_EN
            ST_FFT: begin
                if (fft_ok)          state_next = ST_HOLD;
                else if (to_expired) state_next = ST_IDLE;
            end
`endif
            ST_HOLD:   if (in_vblank) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        samp_start_d = (state == ST_IDLE) && (state_next == ST_SAMPLE);
`ifdef SCHED_FFT_BYPASS_EN
        fft_start_d  = 1'b0;
`else
        fft_start_d  = (state != ST_FFT) && (state_next == ST_FFT);
`endif
        commit_d     = (state_next == ST_COMMIT);
        timeout_evt  = to_expired && (((state == ST_SAMPLE) && !samp_ok) ||
                                      ((state == ST_FFT) && !fft_ok));
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            vsync_q        <= 1'b1;
            div_cnt        <= DIV_MAX;
            samp_start     <= 1'b0;
            fft_start      <= 1'b0;
            commit         <= 1'b0;
            timeout_err    <= 1'b0;
            frames_dropped <= '0;
        end else begin
            vsync_q    <= vsync;
            samp_start <= samp_start_d;
            fft_start  <= fft_start_d;
            commit     <= commit_d;
            // Parking the divider at its terminal value makes the first tick after enable capture.
            if (!enable)         div_cnt <= DIV_MAX;
            else if (frame_tick) div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);
            if (timeout_evt)  timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
            if (drop_evt)     frames_dropped <= err_clr ? DROP_CNT_W'(1) : sat_inc_drop(frames_dropped);
            else if (err_clr) frames_dropped <= '0;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_capture_scheduler.sv
// Directed bench for capture_scheduler using three instances with different divider/timeout settings.
module tb_capture_scheduler;

    logic clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    logic rst, enable, vsync, in_vblank, samp_done, fft_done, err_clr;
    logic [2:0]      samp_start, fft_start, commit, busy, timeout_err;
    logic [2:0][7:0] frames_dropped;
    logic [2:0][2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: FRAME_DIV=1, long timeout. 1: FRAME_DIV=1, TIMEOUT=50. 2: FRAME_DIV=3, TIMEOUT=50.
    capture_scheduler #(.FRAME_DIV(1), .TIMEOUT_CYC(5000)) u_a (
        .clk_25(clk_25), .rst(rst), .enable(enable), .vsync(vsync), .in_vblank(in_vblank),
        .samp_start(samp_start[0]), .samp_done(samp_done), .fft_start(fft_start[0]),
        .fft_done(fft_done), .commit(commit[0]), .busy(busy[0]), .timeout_err(timeout_err[0]),
        .frames_dropped(frames_dropped[0]), .err_clr(err_clr), .state_o(state_o[0]));
    capture_scheduler #(.FRAME_DIV(1), .TIMEOUT_CYC(50)) u_b (
        .clk_25(clk_25), .rst(rst), .enable(enable), .vsync(vsync), .in_vblank(in_vblank),
        .samp_start(samp_start[1]), .samp_done(samp_done), .fft_start(fft_start[1]),
        .fft_done(fft_done), .commit(commit[1]), .busy(busy[1]), .timeout_err(timeout_err[1]),
        .frames_dropped(frames_dropped[1]), .err_clr(err_clr), .state_o(state_o[1]));
    capture_scheduler #(.FRAME_DIV(3), .TIMEOUT_CYC(50)) u_c (
        .clk_25(clk_25), .rst(rst), .enable(enable), .vsync(vsync), .in_vblank(in_vblank),
        .samp_start(samp_start[2]), .samp_done(samp_done), .fft_start(fft_start[2]),
        .fft_done(fft_done), .commit(commit[2]), .busy(busy[2]), .timeout_err(timeout_err[2]),
        .frames_dropped(frames_dropped[2]), .err_clr(err_clr), .state_o(state_o[2]));

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; enable = 1'b1; vsync = 1'b1; in_vblank = 1'b0;
        samp_done = 1'b0; fft_done = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vsync = (i % 2 == 1);
            samp_done = 1'b1;
            step();
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if ({samp_start[d], fft_start[d], commit[d], busy[d], timeout_err[d]} !== 5'b0 ||
                    frames_dropped[d] !== 8'd0 || state_o[d] !== 3'd0) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cyc%0d: pulses/busy/err=%b drops=%0d state=%0d, want all 0",
                             d, i, {samp_start[d], fft_start[d], commit[d], busy[d], timeout_err[d]},
                             frames_dropped[d], state_o[d]);
                end
            end
        end
        idle_inputs();
        step();
        n_checks++;
        if (busy !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release busy=%b want 000", busy);
        end
    endtask

    task automatic test_nominal();
        logic [2:0] exp_st;
        do_reset();
        for (int c = 0; c <= 520; c++) begin
            n_checks++;
            if (samp_start[0] !== (c == 1) || fft_start[0] !== (c == 101) || commit[0] !== (c == 501)) begin
                n_fail++;
                $display("FAIL nominal pulses c=%0d samp/fft/commit=%b%b%b want %b%b%b", c,
                         samp_start[0], fft_start[0], commit[0], c == 1, c == 101, c == 501);
            end
            n_checks++;
            if (busy[0] !== (c >= 1 && c <= 501)) begin
                n_fail++;
                $display("FAIL nominal busy c=%0d got %b want %b", c, busy[0], (c >= 1 && c <= 501));
            end
            if (c == 50 || c == 200 || c == 400) begin
                exp_st = (c == 50) ? 3'd1 : (c == 200) ? 3'd2 : 3'd3;
                n_checks++;
                if (state_o[0] !== exp_st) begin
                    n_fail++;
                    $display("FAIL nominal state c=%0d got %0d want %0d", c, state_o[0], exp_st);
                end
            end
            vsync     = !(c < 10);
            samp_done = (c == 100);
            fft_done  = (c == 300);
            in_vblank = (c >= 500 && c < 510);
            step();
        end
        n_checks++;
        if (timeout_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal timeout_err got %b want 0", timeout_err[0]);
        end
    endtask

    task automatic test_timeout();
        logic exp_busy, exp_err;
        do_reset();
        for (int c = 0; c <= 130; c++) begin
            exp_busy = (c >= 1 && c <= 50) || (c >= 61 && c <= 110);
            exp_err  = (c >= 51 && c <= 62) || (c >= 111);
            n_checks++;
            if (busy[1] !== exp_busy || timeout_err[1] !== exp_err || commit[1] !== 1'b0 ||
                samp_start[1] !== (c == 1 || c == 61)) begin
                n_fail++;
                $display("FAIL timeout c=%0d busy/err/commit/sstart=%b%b%b%b want %b%b0%b", c,
                         busy[1], timeout_err[1], commit[1], samp_start[1],
                         exp_busy, exp_err, (c == 1 || c == 61));
            end
            vsync   = !((c < 5) || (c >= 60 && c < 65));
            err_clr = (c == 62);
            step();
        end
    endtask

    task automatic test_divider();
        do_reset();
        for (int c = 0; c <= 365; c++) begin
            n_checks++;
            if (samp_start[2] !== (c == 1 || c == 181)) begin
                n_fail++;
                $display("FAIL divider samp_start c=%0d got %b want %b", c, samp_start[2], (c == 1 || c == 181));
            end
            vsync = !((c % 60) < 5 && c < 360);
            step();
        end
        n_checks++;
        if (frames_dropped[2] !== 8'd0) begin
            n_fail++;
            $display("FAIL divider drops got %0d want 0", frames_dropped[2]);
        end
    endtask

    task automatic test_drop();
        logic [7:0] exp_fd;
        do_reset();
        for (int c = 0; c <= 1210; c++) begin
            if ((c % 4 == 1 && c <= 1201) || c == 1205 || c == 1209) begin
                if (c == 1205)      exp_fd = 8'd1;
                else if (c == 1209) exp_fd = 8'd0;
                else                exp_fd = (c / 4 > 255) ? 8'd255 : 8'(c / 4);
                n_checks++;
                if (frames_dropped[0] !== exp_fd) begin
                    n_fail++;
                    $display("FAIL drop c=%0d got %0d want %0d", c, frames_dropped[0], exp_fd);
                end
            end
            vsync   = !((c % 4) < 2 && c < 1206);
            err_clr = (c == 1204 || c == 1208);
            step();
        end
    endtask

    task automatic test_edge_cases();
        logic [2:0] exp_st;
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            if (c == 0)       exp_st = 3'd0;
            else if (c <= 2)  exp_st = 3'd1;
            else if (c <= 52) exp_st = 3'd2;
            else if (c <= 55) exp_st = 3'd3;
            else if (c == 56) exp_st = 3'd4;
            else              exp_st = 3'd0;
            n_checks++;
            if (state_o[1] !== exp_st || timeout_err[1] !== 1'b0 ||
                fft_start[1] !== (c == 3) || commit[1] !== (c == 56)) begin
                n_fail++;
                $display("FAIL done_at_expiry c=%0d state=%0d err=%b fstart=%b commit=%b want %0d 0 %b %b",
                         c, state_o[1], timeout_err[1], fft_start[1], commit[1], exp_st, (c == 3), (c == 56));
            end
            vsync     = !(c < 5);
            samp_done = (c == 2);
            fft_done  = (c == 52);
            in_vblank = (c == 55);
            step();
        end
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            exp_st = (c == 0) ? 3'd0 : (c <= 2) ? 3'd1 : 3'd2;
            n_checks++;
            if (state_o[1] !== exp_st || fft_start[1] !== (c == 3)) begin
                n_fail++;
                $display("FAIL stale_samp_done c=%0d state=%0d fstart=%b want %0d %b",
                         c, state_o[1], fft_start[1], exp_st, (c == 3));
            end
            vsync     = !(c < 3);
            samp_done = 1'b1;
            step();
        end
    endtask

    task automatic test_rst_mid_capture();
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            n_checks++;
            if (busy[0] !== (c >= 1 && c <= 3) || samp_start[0] !== (c == 1) || commit[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid c=%0d busy=%b sstart=%b commit=%b want %b %b 0",
                         c, busy[0], samp_start[0], commit[0], (c >= 1 && c <= 3), (c == 1));
            end
            vsync     = !(c < 2);
            rst       = (c == 3);
            samp_done = (c >= 4);
            in_vblank = (c >= 4);
            step();
        end
    endtask

    task automatic test_enable();
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            n_checks++;
            if (busy[0] !== (c >= 7) || samp_start[2] !== (c == 7)) begin
                n_fail++;
                $display("FAIL enable c=%0d busyA=%b sstartC=%b want %b %b",
                         c, busy[0], samp_start[2], (c >= 7), (c == 7));
            end
            enable = (c >= 6);
            vsync  = !((c >= 1 && c < 3) || c == 6);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_divider();
        test_drop();
        test_edge_cases();
        test_rst_mid_capture();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_scheduler.md
Name: capture_scheduler

Overview:
Frame-synchronous sequencer for the audio capture path. Each selected video frame it starts the mic sampler, then the FFT engine. It holds the result until vertical blank, then issues a one-cycle commit that loads the display bar registers. It replaces ad-hoc state logic in the display top, and adds frame decimation, timeouts and drop/error status.

Parameters:
FRAME_DIV, 1, capture on every Nth frame start (N >= 1)
TIMEOUT_CYC, 2000000, max clk_25 cycles allowed in SAMPLE or FFT (80 ms); must be >= 2
TO_W, $clog2(TIMEOUT_CYC+1), timeout counter width (localparam, not overridable)

Ports:
clk_25  in  1  25 MHz pixel/system clock
rst  in  1  synchronous, active-high reset
enable  in  1  allows new captures to start
vsync  in  1  VGA vsync level, active-low sync pulse, clk_25 domain
in_vblank  in  1  high while VGA is outside the visible area
samp_start  out  1  one-cycle pulse, starts mic sampler
samp_done  in  1  sampler finished (pulse or level)
fft_start  out  1  one-cycle pulse, starts FFT
fft_done  in  1  FFT finished (pulse or level)
commit  out  1  one-cycle pulse, load bar registers from FFT output
busy  out  1  state != IDLE
timeout_err  out  1  sticky, a stage timed out
frames_dropped  out  8  saturating count of triggers skipped while busy
err_clr  in  1  clears timeout_err and frames_dropped
state_o  out  3  current state encoding, debug only

Behaviour:
- Reset is synchronous on the clk_25 edge, active-high. On reset:
  - State goes to IDLE. All pulse outputs are 0. timeout_err is 0. frames_dropped is 0.
  - vsync_q is 1. div_cnt is FRAME_DIV-1.
- frame_tick = vsync_q & ~vsync, i.e. the falling edge of vsync. vsync_q is vsync registered by one cycle.
- Frame divider (div_cnt):
  - On frame_tick, div_cnt wraps FRAME_DIV-1 -> 0, otherwise increments.
  - trigger = frame_tick & (div_cnt == FRAME_DIV-1) & enable. The first tick after reset therefore triggers.
  - While enable is low, div_cnt is held at FRAME_DIV-1.
- State encoding: IDLE=0, SAMPLE=1, FFT=2, HOLD=3, COMMIT=4.
- IDLE: trigger -> SAMPLE. samp_start is high for exactly the first cycle in SAMPLE, i.e. the cycle after the tick cycle.
- SAMPLE:
  - samp_done is honoured only from the second cycle in the state onward, so a stale level is ignored.
  - samp_done -> FFT. fft_start is high for the first cycle in FFT.
- FFT:
  - fft_done follows the same second-cycle rule as samp_done.
  - fft_done -> HOLD.
- HOLD: in_vblank high -> COMMIT. HOLD has no timeout.
- COMMIT: commit is high for exactly this one cycle, then -> IDLE.
- Timeout counter:
  - Cleared on every state entry. Increments each cycle in SAMPLE or FFT.
  - When the count reaches TIMEOUT_CYC-1 and no valid done arrives that cycle: go to IDLE, set timeout_err, no commit.
  - A valid done in the same cycle as expiry wins; no error is raised.
- Trigger while state != IDLE: no capture starts; frames_dropped increments, saturating at 255.
- err_clr clears timeout_err and frames_dropped. If a set/increment event occurs in the same cycle, the event wins: timeout_err=1, or frames_dropped=1 after clear.
- enable falling mid-capture: the current capture runs to COMMIT or timeout. No new triggers start.
- rst mid-capture: immediate return to the reset state. No commit or start pulse is emitted.
- samp_done or fft_done outside its own state is ignored.
- Outputs are registered except busy and state_o, which decode the state register.

Optional Feature:
SCHED_FFT_BYPASS_EN
- Defined: FFT state is unreachable. samp_done goes SAMPLE -> HOLD. fft_start is tied 0 and fft_done is ignored. Used for raw-sample display bring-up.
- Undefined: full SAMPLE -> FFT -> HOLD sequence as above.

Decomposition:
- Package audio_sched_pkg:
  - sched_state_t, 3-bit enum with the encodings above.
  - DEFAULT_TIMEOUT_CYC.
  - DROP_CNT_W = 8.
- One sub-module, sched_timeout_ctr: clear, enable, expiry flag; TO_W wide.

Test Plan:
1. Reset: hold rst 3 cycles with toggling vsync -> all outputs 0, state_o=0, no pulses.
2. Nominal path, FRAME_DIV=1:
   - Stimulus: vsync falls at cycle T; samp_done at T+100; fft_done at T+300; in_vblank rises at T+500.
   - Response: samp_start at T+1; fft_start at T+101; commit at T+501, each exactly 1 cycle; busy falls at T+502.
3. Timeout, TIMEOUT_CYC=50, no samp_done:
   - Response: return to IDLE after 50 cycles in SAMPLE, timeout_err=1, no commit.
   - Next tick starts a new capture. err_clr -> timeout_err=0.
4. Divider, FRAME_DIV=3: 6 vsync falling edges -> samp_start only after ticks 1 and 4.
5. Drop counter:
   - Hold samp_done low with a large TIMEOUT_CYC and apply 300 ticks -> frames_dropped saturates at 255.
   - err_clr together with a tick -> frames_dropped=1.
6. Edge cases:
   - fft_done in the same cycle as timeout expiry -> HOLD, timeout_err stays 0.
   - samp_done level already high on SAMPLE entry -> ignored on cycle 1, accepted on cycle 2.
